// File: rtl/dp_muxnds_pipe.sv
// N-way datapath mux with active-low one-cold selects feeding a 2-entry
// valid/ready output buffer, plus select-violation detection and counting.
module dp_muxnds_pipe #(
  parameter int SIZE   = 64,
  parameter int NUM_IN = 4,
  parameter int ERR_W  = 4
) (
  input  logic                   rclk,
  input  logic                   rst_l,
  input  logic [NUM_IN*SIZE-1:0] din,
  input  logic [NUM_IN-1:0]      sel_l,
  input  logic                   in_vld,
  output logic                   in_rdy,
  output logic [SIZE-1:0]        dout,
  output logic                   dout_vld,
  input  logic                   dout_rdy,
  output logic                   sel_err,
  output logic [ERR_W-1:0]       err_cnt,
  input  logic                   err_clr
);

  generate
    if (NUM_IN < 2 || NUM_IN > 8) begin : g_bad_num_in
      $error("dp_muxnds_pipe: NUM_IN must be in 2..8");
    end
  endgenerate

  logic [SIZE-1:0]  r_head_p1;
  logic [SIZE-1:0]  r_tail_p1;
  logic [1:0]       r_cnt;
  logic             r_in_rdy;
  logic             r_sel_err;
  logic [ERR_W-1:0] r_err_cnt;

  logic [3:0]       w_nzero;
  logic [SIZE-1:0]  w_mux;
  logic             w_legal;
  logic [SIZE-1:0]  w_data_p0;
  logic             w_acc;
  logic             w_pop;
  logic [1:0]       w_cnt_nxt;
  logic [SIZE-1:0]  w_head_nxt;
  logic [SIZE-1:0]  w_tail_nxt;
  logic [ERR_W-1:0] w_err_nxt;

  // Stage p0: decode select; zero the data unless exactly one line is low.
  always_comb begin
    w_nzero = 4'd0;
    w_mux   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!sel_l[k]) begin
        w_nzero = w_nzero + 4'd1;
        w_mux   = w_mux | din[k*SIZE +: SIZE];
      end
    end
    w_legal   = (w_nzero == 4'd1);
    w_data_p0 = w_legal ? w_mux : '0;
  end

  assign w_acc = in_vld & r_in_rdy;
  assign w_pop = (r_cnt != 2'd0) & dout_rdy;

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_head_nxt = r_head_p1;
    w_tail_nxt = r_tail_p1;
    case ({w_acc, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
    if (w_pop && r_cnt == 2'd2)
      w_head_nxt = r_tail_p1;
    else if (w_acc && (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop)))
      w_head_nxt = w_data_p0;
    if (w_acc && r_cnt == 2'd1 && !w_pop)
      w_tail_nxt = w_data_p0;
  end

  // A clear coinciding with an illegal accept still records that accept.
  always_comb begin
    w_err_nxt = r_err_cnt;
    if (w_acc && !w_legal) begin
      if (err_clr)
        w_err_nxt = ERR_W'(1);
      else if (r_err_cnt != {ERR_W{1'b1}})
        w_err_nxt = r_err_cnt + ERR_W'(1);
    end else if (err_clr) begin
      w_err_nxt = '0;
    end
  end

  // Stage p1: output buffer and status registers.
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      r_head_p1 <= '0;
      r_tail_p1 <= '0;
      r_cnt     <= 2'd0;
      r_in_rdy  <= 1'b0;
      r_sel_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_head_p1 <= w_head_nxt;
      r_tail_p1 <= w_tail_nxt;
      r_cnt     <= w_cnt_nxt;
      r_in_rdy  <= (w_cnt_nxt != 2'd2);
      r_sel_err <= w_acc & ~w_legal;
      r_err_cnt <= w_err_nxt;
    end
  end

  assign in_rdy   = r_in_rdy;
  assign dout     = r_head_p1;
  assign dout_vld = (r_cnt != 2'd0);
  assign sel_err  = r_sel_err;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_dp_muxnds_pipe.sv
// Directed plus randomized bench for dp_muxnds_pipe against a queue-based
// reference model of the mux, buffer and error counter.
module tb_dp_muxnds_pipe;

  logic         rclk = 1'b0;
  logic         rst_l = 1'b0;
  logic [255:0] din = '0;
  logic [3:0]   sel_l = 4'hF;
  logic         in_vld = 1'b0;
  logic         in_rdy;
  logic [63:0]  dout;
  logic         dout_vld;
  logic         dout_rdy = 1'b0;
  logic         sel_err;
  logic [3:0]   err_cnt;
  logic         err_clr = 1'b0;

  dp_muxnds_pipe #(.SIZE(64), .NUM_IN(4), .ERR_W(4)) dut (
    .rclk(rclk), .rst_l(rst_l), .din(din), .sel_l(sel_l), .in_vld(in_vld),
    .in_rdy(in_rdy), .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .sel_err(sel_err), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 rclk = ~rclk;

  int n_pass = 0;
  int n_total = 0;

  logic [63:0] q[$];
  logic        m_rdy = 1'b0;
  logic [63:0] m_dout = '0;
  logic        m_serr = 1'b0;
  int          m_err = 0;
  bit          m_last_acc = 0;

  function automatic logic [63:0] ref_data(logic [255:0] d, logic [3:0] s);
    if ($countones(~s) != 1) return 64'd0;
    for (int k = 0; k < 4; k++)
      if (!s[k]) return d[k*64 +: 64];
    return 64'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input bit vld, input logic [3:0] s, input int lane, input logic [63:0] val);
    for (int k = 0; k < 4; k++) din[k*64 +: 64] = {$urandom(), $urandom()};
    if (lane >= 0 && lane < 4) din[lane*64 +: 64] = val;
    sel_l  = s;
    in_vld = vld;
  endtask

  // Advance one edge, updating the model from the inputs seen at that edge.
  task automatic tick(input string tag);
    bit acc, pop, ill;
    logic [63:0] d;
    acc = 0;
    if (!rst_l) begin
      q.delete();
      m_rdy = 0; m_dout = '0; m_serr = 0; m_err = 0;
    end else begin
      acc = in_vld && m_rdy;
      pop = (q.size() > 0) && dout_rdy;
      ill = ($countones(~sel_l) != 1);
      d   = ref_data(din, sel_l);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(d);
      m_rdy  = (q.size() != 2);
      m_serr = acc && ill;
      if (acc && ill) m_err = err_clr ? 1 : ((m_err < 15) ? m_err + 1 : 15);
      else if (err_clr) m_err = 0;
      if (q.size() > 0) m_dout = q[0];
    end
    m_last_acc = acc;
    @(posedge rclk);
    #1;
    chk({tag, ".in_rdy"}, 64'(in_rdy), 64'(m_rdy));
    chk({tag, ".dout_vld"}, 64'(dout_vld), 64'(q.size() > 0));
    chk({tag, ".dout"}, dout, m_dout);
    chk({tag, ".sel_err"}, 64'(sel_err), 64'(m_serr));
    chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(m_err));
  endtask

  initial begin
    logic [3:0] rot[4];
    bit done;
    rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011; rot[3] = 4'b0111;

    // reset held two cycles, then released
    rst_l = 0;
    tick("rst0");
    tick("rst1");
    chk("reset.in_rdy", 64'(in_rdy), 64'd0);
    chk("reset.dout", dout, 64'd0);
    rst_l = 1;
    tick("release");
    chk("release.in_rdy", 64'(in_rdy), 64'd1);

    // single transfer through input 2
    dout_rdy = 1;
    drive(1, 4'b1011, 2, 64'hA5A5);
    tick("single");
    chk("single.dout_direct", dout, 64'hA5A5);
    chk("single.vld_direct", 64'(dout_vld), 64'd1);
    drive(0, 4'hF, -1, 0);
    tick("idle0");
    tick("idle1");

    // backpressure fill, then drain in order
    dout_rdy = 0;
    drive(1, 4'b1110, 0, 64'd1); tick("bp1");
    drive(1, 4'b1101, 1, 64'd2); tick("bp2");
    drive(1, 4'b0111, 3, 64'd3); tick("bp3a");
    chk("bp.full_in_rdy", 64'(in_rdy), 64'd0);
    chk("bp.hold_dout", dout, 64'd1);
    tick("bp3b");
    dout_rdy = 1;
    done = 0;
    for (int i = 0; i < 6 && !done; i++) begin
      tick("bp_drain");
      done = m_last_acc;
    end
    chk("bp.accept3_within_bound", 64'(done), 64'd1);
    drive(0, 4'hF, -1, 0);
    for (int i = 0; i < 3; i++) tick("bp_idle");

    // streaming with rotating selects
    for (int i = 0; i < 10; i++) begin
      drive(1, rot[i % 4], i % 4, 64'(100 + i));
      tick("stream");
    end
    drive(0, 4'hF, -1, 0);
    err_clr = 1; tick("clr0"); err_clr = 0;

    // two illegal selects
    drive(1, 4'b1111, -1, 0); tick("ill_all1");
    chk("ill_all1.dout", dout, 64'd0);
    drive(1, 4'b1001, -1, 0); tick("ill_two0");
    chk("ill_two0.sel_err", 64'(sel_err), 64'd1);
    chk("ill_pair.err_cnt", 64'(err_cnt), 64'd2);

    // saturation
    for (int i = 0; i < 20; i++) begin
      drive(1, 4'($urandom_range(0, 15)) & 4'b0011, -1, 0);
      tick("sat");
    end
    chk("sat.err_cnt", 64'(err_cnt), 64'd15);

    // clear colliding with an illegal accept
    drive(0, 4'hF, -1, 0);
    err_clr = 1; tick("clr1"); err_clr = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'b0000, -1, 0); tick("ill5");
    end
    chk("pre_collide.err_cnt", 64'(err_cnt), 64'd5);
    drive(1, 4'b1111, -1, 0);
    err_clr = 1; tick("collide"); err_clr = 0;
    chk("collide.err_cnt", 64'(err_cnt), 64'd1);
    chk("collide.sel_err", 64'(sel_err), 64'd1);
    drive(0, 4'hF, -1, 0); tick("post_collide");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : rot[$urandom_range(0, 3)];
      drive(bit'($urandom_range(0, 3) != 0), s, -1, 0);
      dout_rdy = ($urandom_range(0, 2) != 0);
      err_clr  = ($urandom_range(0, 30) == 0);
      illegal_guard: tick("rand");
    end
    err_clr = 0;

    // reset while two entries are buffered
    drive(0, 4'hF, -1, 0);
    dout_rdy = 1;
    for (int i = 0; i < 3; i++) tick("pre_mid");
    dout_rdy = 0;
    drive(1, 4'b1110, 0, 64'h11); tick("mid_fill1");
    drive(1, 4'b1101, 1, 64'h22); tick("mid_fill2");
    chk("mid.full_vld", 64'(dout_vld), 64'd1);
    rst_l = 0;
    tick("mid_rst");
    chk("mid_rst.dout_vld", 64'(dout_vld), 64'd0);
    chk("mid_rst.dout", dout, 64'd0);
    chk("mid_rst.in_rdy", 64'(in_rdy), 64'd0);
    rst_l = 1;
    drive(0, 4'hF, -1, 0);
    dout_rdy = 1;
    tick("mid_rel");
    chk("mid_rel.in_rdy", 64'(in_rdy), 64'd1);
    for (int i = 0; i < 3; i++) tick("mid_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
